// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the modulo-N counter family.
package cnt_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Smallest r with 2**r >= value; lets parents size WIDTH from MODULUS.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/modn_step.sv
// Combinational next-count for one enabled step, with boundary detect.
// Out-of-range inputs collapse to 0 so a faulted count recovers on the next step.
module modn_step
  import cnt_pkg::*;
#(
  parameter int MODULUS  = 5,
  parameter int WIDTH    = 3,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             up,
  output logic [WIDTH-1:0] nxt,
  output logic             boundary
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MODULUS);

  always_comb begin
    nxt      = cur;
    boundary = 1'b0;
    if ({1'b0, cur} >= MOD_W) begin
      nxt = '0;
    end else if (up == DIR_UP) begin
      // Explicit compare so MODULUS == 2**WIDTH never relies on overflow.
      if (cur == MAX_VAL) begin
        boundary = 1'b1;
        nxt      = (SATURATE == MODE_SAT) ? cur : '0;
      end else begin
        nxt = cur + WIDTH'(1);
      end
    end else begin
      if (cur == '0) begin
        boundary = 1'b1;
        nxt      = (SATURATE == MODE_SAT) ? cur : MAX_VAL;
      end else begin
        nxt = cur - WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with clear, range-checked load, wrap/saturate mode.
// All outputs are registered; flags are computed from the next count.
module modn_updown_counter
  import cnt_pkg::*;
#(
  parameter int MODULUS  = 5,
  parameter int WIDTH    = 3,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             at_max,
  output logic             at_min,
  output logic             evt,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MODULUS);

  if (MODULUS < 2 || (64'd1 << WIDTH) < 64'(MODULUS)) begin : g_bad_params
    $error("modn_updown_counter: need MODULUS >= 2 and 2**WIDTH >= MODULUS");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             at_max_q, at_max_d;
  logic             at_min_q, at_min_d;
  logic             evt_q, evt_d;
  logic             load_err_q, load_err_d;
  logic [WIDTH-1:0] step_nxt;
  logic             step_boundary;

  modn_step #(
    .MODULUS (MODULUS),
    .WIDTH   (WIDTH),
    .SATURATE(SATURATE)
  ) u_step (
    .cur     (cnt_q),
    .up      (up),
    .nxt     (step_nxt),
    .boundary(step_boundary)
  );

  // clr > load > en; a rejected load also swallows the same-cycle step.
  always_comb begin
    cnt_d      = cnt_q;
    evt_d      = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      if ({1'b0, load_val} < MOD_W) cnt_d = load_val;
      else                          load_err_d = 1'b1;
    end else if (en) begin
      cnt_d = step_nxt;
      evt_d = step_boundary;
    end
    at_max_d = (cnt_d == MAX_VAL);
    at_min_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      at_max_q   <= 1'b0;
      at_min_q   <= 1'b1;
      evt_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      at_max_q   <= at_max_d;
      at_min_q   <= at_min_d;
      evt_q      <= evt_d;
      load_err_q <= load_err_d;
    end
  end

  assign cnt      = cnt_q;
  assign at_max   = at_max_q;
  assign at_min   = at_min_q;
  assign evt      = evt_q;
  assign load_err = load_err_q;

endmodule
